// File: rtl/axi_rd_arb_if.sv
// Bus bundle for the two-requester AXI read arbiter.
// Names are seen from the arbiter: I_* flow into it and O_* flow out of it.
// The master modport is the arbiter itself. The slave modport is the
// environment, which drives the requesters and the downstream slave.
interface axi_rd_arb_if #(
  parameter int unsigned C_DATA_WIDTH = 128,
  parameter int unsigned C_ADDR_WIDTH = 32
);

  // Requester-facing AR channel
  logic [2*C_ADDR_WIDTH-1:0] I_req_araddr;
  logic [15:0]               I_req_arlen;
  logic [1:0]                I_req_arvalid;
  logic [1:0]                O_req_arready;

  // Requester-facing R channel; data and tags are broadcast to both requesters
  logic [C_DATA_WIDTH-1:0]   O_req_rdata;
  logic [1:0]                O_req_rvalid;
  logic                      O_req_rlast;
  logic [1:0]                O_req_rresp;
  logic [1:0]                I_req_rready;

  // Downstream AR channel
  logic [C_ADDR_WIDTH-1:0]   O_araddr;
  logic [7:0]                O_arlen;
  logic [3:0]                O_arid;
  logic                      O_arvalid;
  logic                      I_arready;

  // Downstream R channel
  logic [C_DATA_WIDTH-1:0]   I_rdata;
  logic                      I_rvalid;
  logic                      I_rlast;
  logic [1:0]                I_rresp;
  logic [3:0]                I_rid;
  logic                      O_rready;

  // Status
  logic [1:0]                O_grant;
  logic                      O_busy;
  logic                      O_err;

  modport master (
    input  I_req_araddr, I_req_arlen, I_req_arvalid, I_req_rready,
    input  I_arready, I_rdata, I_rvalid, I_rlast, I_rresp, I_rid,
    output O_req_arready, O_req_rdata, O_req_rvalid, O_req_rlast, O_req_rresp,
    output O_araddr, O_arlen, O_arid, O_arvalid, O_rready,
    output O_grant, O_busy, O_err
  );

  modport slave (
    output I_req_araddr, I_req_arlen, I_req_arvalid, I_req_rready,
    output I_arready, I_rdata, I_rvalid, I_rlast, I_rresp, I_rid,
    input  O_req_arready, O_req_rdata, O_req_rvalid, O_req_rlast, O_req_rresp,
    input  O_araddr, O_arlen, O_arid, O_arvalid, O_rready,
    input  O_grant, O_busy, O_err
  );

endinterface

// File: rtl/axi_rd_arb.sv
// Two-requester AXI read arbiter. It keeps one burst outstanding at a time
// and grants round-robin between the two requesters.
// The R channel is routed to the current owner, and the beats of each burst
// are counted against the requested length. A protocol error sets a sticky
// flag. An error never cuts a burst short; only I_rlast ends the data phase.
module axi_rd_arb #(
  parameter int unsigned C_DATA_WIDTH = 128,
  parameter int unsigned C_ADDR_WIDTH = 32
) (
  input  logic          I_aclk,
  input  logic          I_arst,
  axi_rd_arb_if.master  io_bus
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAddr = 2'd1,
    StData = 2'd2
  } state_e;

  localparam int unsigned AW = C_ADDR_WIDTH;

  // State registers
  state_e          r_state;
  logic            r_g;          // current owner index
  logic            r_last;       // last owner; a tie goes to the other requester
  logic [8:0]      r_cnt;        // beats accepted so far in this burst
  logic [8:0]      r_exp;        // beats expected in this burst (arlen + 1)
  logic [AW-1:0]   r_araddr;
  logic [7:0]      r_arlen;
  logic [3:0]      r_arid;
  logic            r_arvalid;
  logic            r_err;

  // Next-state values
  state_e          w_state_nxt;
  logic            w_g_nxt;
  logic            w_last_nxt;
  logic [8:0]      w_cnt_nxt;
  logic [8:0]      w_exp_nxt;
  logic [AW-1:0]   w_araddr_nxt;
  logic [7:0]      w_arlen_nxt;
  logic [3:0]      w_arid_nxt;
  logic            w_arvalid_nxt;
  logic            w_err_nxt;

  // Combinational outputs
  logic [1:0]      w_grant;
  logic [1:0]      w_req_arready;
  logic [1:0]      w_req_rvalid;
  logic            w_rready;

  // Arbitration and beat helpers
  logic            w_any_req;
  logic            w_pick;
  logic [AW-1:0]   w_sel_addr;
  logic [7:0]      w_sel_len;
  logic            w_beat;
  logic [8:0]      w_cnt_inc;
  logic            w_unused;

  assign w_any_req = |io_bus.I_req_arvalid;
  // With both requesting, the one that did not own the last burst wins.
  // A lone requester wins no matter where the pointer stands.
  assign w_pick     = (&io_bus.I_req_arvalid) ? ~r_last : io_bus.I_req_arvalid[1];
  assign w_sel_addr = w_pick ? io_bus.I_req_araddr[2*AW-1:AW] : io_bus.I_req_araddr[AW-1:0];
  assign w_sel_len  = w_pick ? io_bus.I_req_arlen[15:8] : io_bus.I_req_arlen[7:0];
  assign w_beat     = (r_state == StData) & io_bus.I_rvalid & w_rready;
  assign w_cnt_inc  = r_cnt + 9'd1;

  // Only the low ID bit identifies the requester
  assign w_unused = ^io_bus.I_rid[3:1];

  // State register with synchronous reset
  always_ff @(posedge I_aclk) begin
    if (I_arst) begin
      r_state   <= StIdle;
      r_g       <= 1'b0;
      r_last    <= 1'b1;
      r_cnt     <= 9'd0;
      r_exp     <= 9'd0;
      r_araddr  <= '0;
      r_arlen   <= 8'd0;
      r_arid    <= 4'd0;
      r_arvalid <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_g       <= w_g_nxt;
      r_last    <= w_last_nxt;
      r_cnt     <= w_cnt_nxt;
      r_exp     <= w_exp_nxt;
      r_araddr  <= w_araddr_nxt;
      r_arlen   <= w_arlen_nxt;
      r_arid    <= w_arid_nxt;
      r_arvalid <= w_arvalid_nxt;
      r_err     <= w_err_nxt;
    end
  end

  // Next-state logic: grant, address issue, beat counting and error detection
  always_comb begin
    w_state_nxt   = r_state;
    w_g_nxt       = r_g;
    w_last_nxt    = r_last;
    w_cnt_nxt     = r_cnt;
    w_exp_nxt     = r_exp;
    w_araddr_nxt  = r_araddr;
    w_arlen_nxt   = r_arlen;
    w_arid_nxt    = r_arid;
    w_arvalid_nxt = r_arvalid;
    w_err_nxt     = r_err;

    unique case (r_state)
      StIdle: begin
        // No burst is outstanding, so any data beat is a stray
        if (io_bus.I_rvalid) w_err_nxt = 1'b1;
        if (w_any_req) begin
          w_state_nxt   = StAddr;
          w_g_nxt       = w_pick;
          w_araddr_nxt  = w_sel_addr;
          w_arlen_nxt   = w_sel_len;
          w_arid_nxt    = {3'b000, w_pick};
          w_arvalid_nxt = 1'b1;
        end
      end

      StAddr: begin
        if (io_bus.I_rvalid) w_err_nxt = 1'b1;
        // The registered request issues even if the requester withdrew it
        if (r_arvalid && io_bus.I_arready) begin
          w_arvalid_nxt = 1'b0;
          w_cnt_nxt     = 9'd0;
          w_exp_nxt     = {1'b0, r_arlen} + 9'd1;
          w_state_nxt   = StData;
        end
      end

      StData: begin
        if (w_beat) begin
          w_cnt_nxt = w_cnt_inc;
          if (io_bus.I_rid[0] != r_g) w_err_nxt = 1'b1;
          if (io_bus.I_rlast) begin
            if (w_cnt_inc != r_exp) w_err_nxt = 1'b1;
            w_state_nxt = StIdle;
            w_last_nxt  = r_g;
          end else if (w_cnt_inc == r_exp) begin
            // The final beat arrived without rlast; keep waiting for rlast
            w_err_nxt = 1'b1;
          end
        end
      end

      default: w_state_nxt = StIdle;
    endcase
  end

  // Owner-based routing of the handshake signals
  always_comb begin
    w_grant       = 2'b00;
    w_req_arready = 2'b00;
    w_req_rvalid  = 2'b00;
    w_rready      = 1'b0;
    unique case (r_state)
      StAddr: begin
        w_grant[r_g]       = 1'b1;
        w_req_arready[r_g] = io_bus.I_arready;
      end
      StData: begin
        w_grant[r_g]      = 1'b1;
        w_req_rvalid[r_g] = io_bus.I_rvalid;
        w_rready          = io_bus.I_req_rready[r_g];
      end
      default: ;
    endcase
  end

  assign io_bus.O_req_arready = w_req_arready;
  assign io_bus.O_req_rvalid  = w_req_rvalid;
  assign io_bus.O_rready      = w_rready;
  assign io_bus.O_grant       = w_grant;
  assign io_bus.O_busy        = (r_state != StIdle);
  assign io_bus.O_err         = r_err;

  assign io_bus.O_araddr  = r_araddr;
  assign io_bus.O_arlen   = r_arlen;
  assign io_bus.O_arid    = r_arid;
  assign io_bus.O_arvalid = r_arvalid;

  // Data, last and response are broadcast; the per-requester valid qualifies them
  assign io_bus.O_req_rdata = io_bus.I_rdata;
  assign io_bus.O_req_rlast = io_bus.I_rlast;
  assign io_bus.O_req_rresp = io_bus.I_rresp;

endmodule

// File: tb/tb_axi_rd_arb.sv
// Directed testbench for axi_rd_arb. It covers a single requester,
// round-robin contention, backpressure, burst-length errors and reset in
// the middle of a burst.
module tb_axi_rd_arb;

  localparam int unsigned DW = 128;
  localparam int unsigned AW = 32;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  axi_rd_arb_if #(.C_DATA_WIDTH(DW), .C_ADDR_WIDTH(AW)) bus ();

  axi_rd_arb #(.C_DATA_WIDTH(DW), .C_ADDR_WIDTH(AW)) dut (
    .I_aclk (clk),
    .I_arst (rst),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts every comparison and reports each mismatch
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Advances to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    bus.I_req_araddr  = '0;
    bus.I_req_arlen   = '0;
    bus.I_req_arvalid = '0;
    bus.I_req_rready  = '0;
    bus.I_arready     = 1'b0;
    bus.I_rdata       = '0;
    bus.I_rvalid      = 1'b0;
    bus.I_rlast       = 1'b0;
    bus.I_rresp       = 2'b00;
    bus.I_rid         = 4'd0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    settle();
  endtask

  // Expects the block to be IDLE with a request already presented
  task automatic addr_phase(input int g, input logic [31:0] addr, input logic [7:0] len,
                            input int ar_wait);
    logic [1:0] oh;
    oh = 2'b01 << g;
    tick();
    check("ar_valid", bus.O_arvalid, 1'b1);
    check("ar_addr", bus.O_araddr, addr);
    check("ar_len", bus.O_arlen, len);
    check("ar_id", bus.O_arid, g);
    check("grant_addr", bus.O_grant, oh);
    for (int k = 0; k < ar_wait; k++) begin
      bus.I_arready = 1'b0;
      settle();
      check("req_arready_low", bus.O_req_arready, 2'b00);
      tick();
      check("ar_valid_hold", bus.O_arvalid, 1'b1);
      check("ar_addr_hold", bus.O_araddr, addr);
    end
    bus.I_arready = 1'b1;
    settle();
    check("req_arready", bus.O_req_arready, oh);
    check("rvalid_in_addr", bus.O_req_rvalid, 2'b00);
    tick();
    bus.I_arready = 1'b0;
    settle();
    check("ar_valid_clr", bus.O_arvalid, 1'b0);
    check("busy_data", bus.O_busy, 1'b1);
    check("grant_data", bus.O_grant, oh);
  endtask

  // Delivers nbeats handshaked beats and raises rlast on beat last_idx
  task automatic data_phase(input int g, input int nbeats, input int last_idx, input bit toggle);
    logic [1:0] oh;
    logic       rr;
    int         i;
    int         cyc;
    oh  = 2'b01 << g;
    i   = 0;
    cyc = 0;
    while (i < nbeats && cyc < 200) begin
      rr = toggle ? ((cyc % 2) == 0) : 1'b1;
      bus.I_req_rready = {1'b0, rr} << g;
      bus.I_rvalid     = 1'b1;
      bus.I_rdata      = {96'h0, 32'hD000_0000 + 32'(i)};
      bus.I_rid        = 4'(g);
      bus.I_rlast      = (i == last_idx);
      bus.I_rresp      = 2'b00;
      settle();
      check("req_rvalid", bus.O_req_rvalid, oh);
      check("rready", bus.O_rready, rr);
      check("rdata_order", bus.O_req_rdata, {96'h0, 32'hD000_0000 + 32'(i)});
      if (rr) i++;
      tick();
      cyc++;
    end
    if (i != nbeats) check("beat_timeout", 128'(i), 128'(nbeats));
    bus.I_rvalid     = 1'b0;
    bus.I_rlast      = 1'b0;
    bus.I_req_rready = 2'b00;
    settle();
    check("idle_after_burst", bus.O_busy, 1'b0);
    check("grant_idle", bus.O_grant, 2'b00);
  endtask

  // Guards against a run that never finishes
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    do_reset();

    // Values right after reset
    check("rst_arvalid", bus.O_arvalid, 1'b0);
    check("rst_araddr", bus.O_araddr, 32'h0);
    check("rst_arid", bus.O_arid, 4'h0);
    check("rst_grant", bus.O_grant, 2'b00);
    check("rst_busy", bus.O_busy, 1'b0);
    check("rst_err", bus.O_err, 1'b0);
    check("rst_rready", bus.O_rready, 1'b0);
    check("rst_req_arready", bus.O_req_arready, 2'b00);

    // Single requester: req0, address 0x1000, 4 beats
    bus.I_req_araddr[31:0] = 32'h1000;
    bus.I_req_arlen[7:0]   = 8'd3;
    bus.I_req_arvalid      = 2'b01;
    settle();
    check("idle_grant_zero", bus.O_grant, 2'b00);
    addr_phase(0, 32'h1000, 8'd3, 0);
    bus.I_req_arvalid = 2'b00;
    data_phase(0, 4, 3, 1'b0);
    check("single_err", bus.O_err, 1'b0);

    // Contention from reset: the grant alternates 0,1,0,1
    do_reset();
    bus.I_req_araddr  = {32'h3000, 32'h2000};
    bus.I_req_arlen   = {8'd1, 8'd0};
    bus.I_req_arvalid = 2'b11;
    settle();
    for (int b = 0; b < 4; b++) begin
      if ((b % 2) == 0) begin
        addr_phase(0, 32'h2000, 8'd0, 0);
        data_phase(0, 1, 0, 1'b0);
      end else begin
        addr_phase(1, 32'h3000, 8'd1, 0);
        data_phase(1, 2, 1, 1'b0);
      end
    end
    bus.I_req_arvalid = 2'b00;
    check("contention_err", bus.O_err, 1'b0);

    // Backpressure: arready held low for 5 cycles, then rready toggles
    bus.I_req_araddr[63:32] = 32'h4000;
    bus.I_req_arlen[15:8]   = 8'd2;
    bus.I_req_arvalid       = 2'b10;
    settle();
    addr_phase(1, 32'h4000, 8'd2, 5);
    bus.I_req_arvalid = 2'b00;
    data_phase(1, 3, 2, 1'b1);
    check("backpressure_err", bus.O_err, 1'b0);

    // Early rlast: arlen=3, rlast on the second beat
    bus.I_req_araddr[31:0] = 32'h5000;
    bus.I_req_arlen[7:0]   = 8'd3;
    bus.I_req_arvalid      = 2'b01;
    settle();
    addr_phase(0, 32'h5000, 8'd3, 0);
    bus.I_req_arvalid = 2'b00;
    data_phase(0, 2, 1, 1'b0);
    check("early_last_err", bus.O_err, 1'b1);
    // A clean burst afterwards leaves the sticky flag set
    bus.I_req_arvalid = 2'b10;
    bus.I_req_arlen[15:8] = 8'd0;
    settle();
    addr_phase(1, 32'h4000, 8'd0, 0);
    bus.I_req_arvalid = 2'b00;
    data_phase(1, 1, 0, 1'b0);
    check("err_sticky", bus.O_err, 1'b1);

    // Reset during the second data beat
    do_reset();
    bus.I_req_araddr[31:0] = 32'h6000;
    bus.I_req_arlen[7:0]   = 8'd3;
    bus.I_req_arvalid      = 2'b01;
    settle();
    addr_phase(0, 32'h6000, 8'd3, 0);
    bus.I_req_arvalid = 2'b00;
    bus.I_req_rready  = 2'b01;
    bus.I_rvalid      = 1'b1;
    bus.I_rid         = 4'd0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.I_rvalid = 1'b0;
    settle();
    check("mid_rst_arvalid", bus.O_arvalid, 1'b0);
    check("mid_rst_araddr", bus.O_araddr, 32'h0);
    check("mid_rst_arlen", bus.O_arlen, 8'h0);
    check("mid_rst_grant", bus.O_grant, 2'b00);
    check("mid_rst_busy", bus.O_busy, 1'b0);
    check("mid_rst_err", bus.O_err, 1'b0);
    check("mid_rst_rready", bus.O_rready, 1'b0);
    // A stray beat after the reset is blocked and flagged
    bus.I_rvalid     = 1'b1;
    bus.I_req_rready = 2'b11;
    settle();
    check("stray_req_rvalid", bus.O_req_rvalid, 2'b00);
    check("stray_rready", bus.O_rready, 1'b0);
    tick();
    bus.I_rvalid     = 1'b0;
    bus.I_req_rready = 2'b00;
    settle();
    check("stray_err", bus.O_err, 1'b1);
    // A new request from req1 is granted first
    bus.I_req_araddr[63:32] = 32'h7000;
    bus.I_req_arlen[15:8]   = 8'd0;
    bus.I_req_arvalid       = 2'b10;
    settle();
    addr_phase(1, 32'h7000, 8'd0, 0);
    bus.I_req_arvalid = 2'b00;
    data_phase(1, 1, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
